// File: rtl/spk_pkg.sv
// Shared constants and FSM state encodings for the I2S speaker/microphone paths.
package spk_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF = 32;
  localparam int unsigned FRAME_BITS = 2 * SLOT_W_DEF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/spk_sample_buf.sv
// One-entry valid/ready holding register; a frame load empties it.
module spk_sample_buf
  import spk_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic accept;
  logic full_nx;

  // An accept can only coincide with a load when the buffer is already empty.
  always_comb begin
    accept  = in_valid && in_ready;
    full_nx = full;
    if (load)   full_nx = 1'b0;
    if (accept) full_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      in_ready <= 1'b1;
      data     <= '0;
    end else begin
      full     <= full_nx;
      in_ready <= !full_nx;
      if (accept) data <= in;
    end
  end

endmodule

// File: rtl/spk_send.sv
// I2S master transmitter, mono sample repeated in both slots, MSB-first.
// Define SPK_UNDERRUN_HOLD_EN to repeat the previous sample on underrun instead of silence.
module spk_send
  import spk_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tick,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              frame_start,
  output logic              underrun,
  output logic              sck,
  output logic              ws,
  output logic              sd
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, slot_pos;
  logic [DATA_W-1:0] shifter, shift_nx;
  logic [DATA_W-1:0] frame, frame_nx;
  logic              load;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;

  spk_sample_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load     (load),
    .full     (buf_full),
    .data     (buf_data)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shifter;
    frame_nx = frame;
    load     = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = LOW;
        end
        LOW: if (tick) state_nx = HIGH;
        HIGH: if (tick) begin
          state_nx = LOW;
          if (cnt == CNT_W'(FRAME_W - 1)) begin
            load   = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
            // Right slot restarts from the held frame sample, not the drained shifter.
            if (cnt_nx == CNT_W'(SLOT_W)) shift_nx = frame;
            else                          shift_nx = {shifter[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
    if (load) begin
      if (buf_full) begin
        frame_nx = buf_data;
      end else begin
`ifdef SPK_UNDERRUN_HOLD_EN
        frame_nx = frame;
`else
        frame_nx = '0;
`endif
      end
      shift_nx = frame_nx;
    end
  end

  assign slot_pos = (cnt >= CNT_W'(SLOT_W)) ? cnt - CNT_W'(SLOT_W) : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shifter     <= '0;
      frame       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      sck         <= 1'b0;
      ws          <= 1'b0;
      sd          <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      shifter     <= shift_nx;
      frame       <= frame_nx;
      frame_start <= load;
      underrun    <= load && !buf_full;
      // Pins follow the current internal state one clk later.
      sck         <= (state == HIGH);
      ws          <= (state != IDLE) && (cnt >= CNT_W'(SLOT_W));
      sd          <= (state != IDLE) && shifter[DATA_W-1] && (slot_pos < CNT_W'(DATA_W));
    end
  end

endmodule

// File: tb/tb_spk_send.sv
// Scoreboard bench for spk_send: expected frames queued by stimulus, checked by a pin monitor.
module tb_spk_send;

  localparam int unsigned TP        = 4;
  localparam int unsigned FRAME_CLK = 2 * 64 * TP;

  typedef struct {
    logic [23:0] data;
    logic        ur;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic [23:0] din = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, frame_start, underrun, sck, ws, sd;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt = 0;
  int   fs_cnt = 0;
  int   ur_cnt = 0;
  int   tph = 0;
  bit   abort_exp = 0;

`ifdef SPK_UNDERRUN_HOLD_EN
  localparam logic [23:0] HOLD_VAL = 24'h123456;
`else
  localparam logic [23:0] HOLD_VAL = 24'h000000;
`endif

  spk_send dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tick        (tick),
    .in          (din),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .underrun    (underrun),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    tph  = (tph + 1) % TP;
    tick = (tph == 0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic u);
    exp_t e;
    e.data = d;
    e.ur   = u;
    sb.push_back(e);
  endtask

  // Accepted samples are pushed in the order the DUT takes them.
  initial forever begin
    @(posedge clk);
    if (!rst && in_valid && in_ready) begin
      acc_cnt++;
      push(din, 1'b0);
    end
  end

  // Monitor: rebuild each 64-bit frame from the pins and compare against the queue.
  initial begin
    int          cyc = 0, last_fs = 0, nbits = 0;
    bit          in_prog = 0, prev_done = 0, sck_q = 0, cur_ur = 0;
    logic [63:0] sdw = '0, wsw = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_prog = 0; prev_done = 0; nbits = 0; sck_q = 0;
        continue;
      end
      if (underrun) begin
        ur_cnt++;
        check("ur_with_fs", 64'(frame_start), 64'd1);
      end
      if (frame_start) begin
        fs_cnt++;
        check("rdy_on_load", 64'(in_ready), 64'd1);
        if (prev_done) check("frame_period", 64'(cyc - last_fs), 64'(FRAME_CLK));
        if (in_prog) begin
          check("abort_expected", 64'(abort_exp), 64'd1);
          abort_exp = 0;
          if (sb.size() > 0) void'(sb.pop_front());
        end
        in_prog = 1; prev_done = 0; nbits = 0; cur_ur = underrun; last_fs = cyc;
      end
      if (sck && !sck_q && in_prog) begin
        sdw = {sdw[62:0], sd};
        wsw = {wsw[62:0], ws};
        nbits++;
        if (nbits == 64) begin
          in_prog = 0; prev_done = 1;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: got frame %0h want none", sdw);
          end else begin
            e = sb.pop_front();
            check("left_slot", 64'(sdw[63:32]), 64'({e.data, 8'h00}));
            check("right_slot", 64'(sdw[31:0]), 64'({e.data, 8'h00}));
            check("ws_pattern", wsw, 64'h0000_0000_FFFF_FFFF);
            check("underrun_flag", 64'(cur_ur), 64'(e.ur));
          end
        end
      end
      sck_q = sck;
    end
  end

  task automatic wait_fs();
    for (int k = 0; k < FRAME_CLK + 64; k++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    check("fs_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_acc(input int target);
    for (int k = 0; k < 2 * FRAME_CLK + 64; k++) begin
      if (acc_cnt >= target) return;
      @(posedge clk);
      #1;
    end
    check("acc_timeout", 64'(acc_cnt), 64'(target));
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_sck"}, 64'(sck), 64'd0);
    check({tag, "_ws"}, 64'(ws), 64'd0);
    check({tag, "_sd"}, 64'(sd), 64'd0);
    check({tag, "_fs"}, 64'(frame_start), 64'd0);
    check({tag, "_ur"}, 64'(underrun), 64'd0);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [23:0] vals[6] = '{24'hA5F00F, 24'h800000, 24'h7FFFFF,
                             24'h800000, 24'h7FFFFF, 24'h5A5A5A};
    int base, fs0, ur0;

    repeat (3) @(negedge clk);
    reset_vals("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Two silent frames, then a continuously fed stream.
    push(24'h0, 1'b1);
    push(24'h0, 1'b1);
    enable = 1'b1;
    wait_fs();
    wait_fs();
    @(posedge clk); #1;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      din = vals[i];
      in_valid = 1'b1;
      wait_acc(base + i + 1);
      if (i == 0) begin
        din = vals[1];
        @(negedge clk);
        check("rdy_after_acc", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;

    // Drop enable in the right slot with a sample still buffered.
    repeat (318) @(posedge clk);
    #1 enable = 1'b0;
    abort_exp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("dis_sck", 64'(sck), 64'd0);
    check("dis_ws", 64'(ws), 64'd0);
    check("dis_sd", 64'(sd), 64'd0);
    check("dis_buf_kept", 64'(in_ready), 64'd0);
    fs0 = fs_cnt; ur0 = ur_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("idle_no_fs", 64'(fs_cnt - fs0), 64'd0);
    check("idle_no_ur", 64'(ur_cnt - ur0), 64'd0);
    push(24'h0, 1'b1);
    enable = 1'b1;
    wait_fs();
    wait_fs();

    // Reset mid-frame with a full buffer; that sample must never play.
    @(posedge clk); #1;
    din = 24'h333333;
    in_valid = 1'b1;
    wait_acc(acc_cnt + 1);
    in_valid = 1'b0;
    repeat (17 * 2 * TP - 4) @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_vals("midrst");
    sb.delete();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push(24'h0, 1'b1);
    enable = 1'b1;
    wait_fs();

    // One sample, then starve the buffer.
    @(posedge clk); #1;
    din = 24'h123456;
    in_valid = 1'b1;
    wait_acc(acc_cnt + 1);
    in_valid = 1'b0;
    push(HOLD_VAL, 1'b1);
    push(HOLD_VAL, 1'b1);

    for (int k = 0; k < 4 * FRAME_CLK && sb.size() > 0; k++) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(30000 * 10);
    tests++; fails++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
